ysyx_22040759_mem_arb: RTL and testbench

- Two-master, one-slave arbiter. It shares the single core memory port between instruction fetch (IF, read-only, 32-bit instructions) and the load/store unit (LS, read/write, 64-bit).
- Sits between the IF stage / LSU and the memory or bus bridge.
- Allows one outstanding transaction at a time.
- Handshake on every side: request/grant for acceptance, then rvalid for completion.

---
 rtl/ysyx_22040759_mem_arb_pkg.sv | 24 ++
 rtl/ysyx_22040759_mem_arb.sv | 186 ++++++++++++++++++
 tb/tb_ysyx_22040759_mem_arb.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040759_mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040759_mem_arb_pkg
// Shared definitions for the IF/LS memory arbiter: FSM state encodings, owner
// encodings and the helper that picks the fetched 32-bit word from a 64-bit beat.
// ----------------------------------------------------------------------------
package ysyx_22040759_mem_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT_IF = 2'd1,
        ARB_WAIT_LS = 2'd2
    } arb_state_e;

    // Owner of the outstanding transaction (also the arbitration winner).
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // Fetches are 4-byte aligned inside a 64-bit beat; addr[2] picks the half.
    function automatic logic [31:0] pick_word(input logic word_sel, input logic [63:0] beat);
        return word_sel ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/ysyx_22040759_mem_arb.sv
// ----------------------------------------------------------------------------
// ysyx_22040759_mem_arb
// Two-master / one-slave arbiter sharing the core memory port between the
// instruction fetch (IF, 32-bit read-only) and the load/store unit (LS, 64-bit
// read/write). One outstanding transaction at a time; request/grant accepts a
// transaction, rvalid completes it. Grants and rvalids are forwarded
// combinationally, so the arbiter adds no cycles on either handshake.
//
// Configuration macro:
//   YSYX_22040759_ARB_RR_EN  defined   -> round-robin between IF and LS on a tie
//                            undefined -> fixed priority, LS always wins
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata      fetch accept, completion pulse, instruction
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_wmask              LSU request and payload (held until ls_gnt)
//   ls_gnt/ls_rvalid/ls_rdata      LSU accept, completion pulse, load data
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wmask            request to memory (wmask 0 for reads)
//   mem_gnt/mem_rvalid/mem_rdata   memory accept, response, read data
//
// DATA_W must be 64: the fetch word select relies on addr[2].
// ----------------------------------------------------------------------------
module ysyx_22040759_mem_arb
    import ysyx_22040759_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [7:0]        ls_wmask,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       word_sel_q, word_sel_d;
    logic       sel;
    logic       any_req;

    assign any_req = if_req | ls_req;

`ifdef YSYX_22040759_ARB_RR_EN
    logic last_owner_q, last_owner_d;

    // On a tie the master that did not win the previous grant goes first.
    always_comb begin
        if (if_req && ls_req) begin
            sel = ~last_owner_q;
        end else if (ls_req) begin
            sel = OWN_LS;
        end else begin
            sel = OWN_IF;
        end
    end
`else
    always_comb begin
        sel = ls_req ? OWN_LS : OWN_IF;
    end
`endif

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IF;
            word_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            word_sel_q <= word_sel_d;
        end
    end

`ifdef YSYX_22040759_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= OWN_IF;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Next state, request mux and response demux
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        word_sel_d = word_sel_q;
`ifdef YSYX_22040759_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif

        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;

        unique case (state_q)
            ARB_IDLE: begin
                mem_req = any_req;
                // Payload only driven while requesting so idle outputs read as 0.
                if (any_req) begin
                    if (sel == OWN_LS) begin
                        mem_we    = ls_we;
                        mem_addr  = ls_addr;
                        mem_wdata = ls_wdata;
                        mem_wmask = ls_we ? ls_wmask : 8'h00;
                    end else begin
                        mem_addr  = if_addr;
                    end
                end

                if (any_req && mem_gnt) begin
                    owner_d = sel;
`ifdef YSYX_22040759_ARB_RR_EN
                    last_owner_d = sel;
`endif
                    if (sel == OWN_LS) begin
                        ls_gnt  = 1'b1;
                        state_d = ARB_WAIT_LS;
                    end else begin
                        if_gnt     = 1'b1;
                        word_sel_d = if_addr[2];
                        state_d    = ARB_WAIT_IF;
                    end
                end
                // mem_rvalid seen here is stale or spurious and is dropped.
            end

            ARB_WAIT_IF, ARB_WAIT_LS: begin
                if (mem_rvalid) begin
                    if (owner_q == OWN_LS) begin
                        ls_rvalid = 1'b1;
                        ls_rdata  = mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = pick_word(word_sel_q, mem_rdata);
                    end
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_22040759_mem_arb.sv
module tb_ysyx_22040759_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [63:0] ls_addr, ls_wdata;
    logic [7:0]  ls_wmask;
    logic        ls_gnt, ls_rvalid;
    logic [63:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt, mem_rvalid;
    logic [63:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_22040759_mem_arb #(
        .ADDR_W(64),
        .DATA_W(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_wmask   (ls_wmask),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0;
        ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    logic exp_ls [4];

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        // Reset state: everything quiet.
        chk("rst_mem_req",   mem_req,   0);
        chk("rst_if_gnt",    if_gnt,    0);
        chk("rst_ls_gnt",    ls_gnt,    0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_ls_rvalid", ls_rvalid, 0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wmask", mem_wmask, 0);
        chk("rst_if_rdata",  if_rdata,  0);
        chk("rst_ls_rdata",  ls_rdata,  0);

        // Lone fetch, high word.
        step();
        if_req = 1; if_addr = 64'h8000_0004; mem_gnt = 1;
        @(negedge clk);
        chk("fetch_gnt",   if_gnt,   1);
        chk("fetch_lsgnt", ls_gnt,   0);
        chk("fetch_req",   mem_req,  1);
        chk("fetch_addr",  mem_addr, 64'h8000_0004);
        chk("fetch_we",    mem_we,   0);
        chk("fetch_wmask", mem_wmask, 0);
        step();
        if_req = 0; mem_gnt = 0;
        @(negedge clk);
        chk("fetch_wait_req", mem_req,   0);
        chk("fetch_wait_rv",  if_rvalid, 0);
        step();
        step();
        mem_rvalid = 1; mem_rdata = 64'h0010_0093_0000_0013;
        @(negedge clk);
        chk("fetch_rvalid",  if_rvalid, 1);
        chk("fetch_rdata",   if_rdata,  32'h0010_0093);
        chk("fetch_ls_rv",   ls_rvalid, 0);
        step();
        mem_rvalid = 0; mem_rdata = '0;
        @(negedge clk);
        chk("fetch_rv_pulse", if_rvalid, 0);

        // Spurious rvalid while idle is dropped.
        step();
        mem_rvalid = 1; mem_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        chk("spur_if_rv", if_rvalid, 0);
        chk("spur_ls_rv", ls_rvalid, 0);
        step();
        mem_rvalid = 0; mem_rdata = '0;

        // Conflict: LS wins (fixed priority, and first tie under round-robin).
        if_req = 1; if_addr = 64'h8000_0000;
        ls_req = 1; ls_we = 1; ls_addr = 64'h8000_2000;
        ls_wdata = 64'h1122_3344_5566_7788; ls_wmask = 8'hFF; mem_gnt = 1;
        @(negedge clk);
        chk("conf_ls_gnt", ls_gnt,    1);
        chk("conf_if_gnt", if_gnt,    0);
        chk("conf_we",     mem_we,    1);
        chk("conf_addr",   mem_addr,  64'h8000_2000);
        chk("conf_wmask",  mem_wmask, 8'hFF);
        chk("conf_wdata",  mem_wdata, 64'h1122_3344_5566_7788);
        step();
        ls_req = 0; ls_we = 0; mem_gnt = 0;
        @(negedge clk);
        chk("conf_wait_req",   mem_req, 0);
        chk("conf_wait_ifgnt", if_gnt,  0);
        step();
        mem_rvalid = 1;
        @(negedge clk);
        chk("conf_ls_rv", ls_rvalid, 1);
        chk("conf_if_rv", if_rvalid, 0);
        step();
        mem_rvalid = 0; mem_gnt = 1;
        @(negedge clk);
        chk("conf_if_gnt2", if_gnt,    1);
        chk("conf_wmask2",  mem_wmask, 0);
        chk("conf_we2",     mem_we,    0);
        chk("conf_addr2",   mem_addr,  64'h8000_0000);
        step();
        if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'hAAAA_AAAA_BBBB_BBBB;
        @(negedge clk);
        chk("conf_if_rv2",   if_rvalid, 1);
        chk("conf_if_rdata", if_rdata,  32'hBBBB_BBBB);
        chk("conf_ls_rv2",   ls_rvalid, 0);
        step();
        idle_inputs();

        // Both requesters continuously active for four transactions.
`ifdef YSYX_22040759_ARB_RR_EN
        exp_ls[0] = 1; exp_ls[1] = 0; exp_ls[2] = 1; exp_ls[3] = 0;
`else
        exp_ls[0] = 1; exp_ls[1] = 1; exp_ls[2] = 1; exp_ls[3] = 1;
`endif
        for (int i = 0; i < 4; i++) begin
            step();
            if_req = 1; if_addr = 64'h8000_0100;
            ls_req = 1; ls_we = 0; ls_addr = 64'h8000_3000; ls_wmask = 8'hFF;
            mem_gnt = 1; mem_rvalid = 0;
            @(negedge clk);
            chk($sformatf("tie%0d_ls_gnt", i), ls_gnt, exp_ls[i]);
            chk($sformatf("tie%0d_if_gnt", i), if_gnt, !exp_ls[i]);
            chk($sformatf("tie%0d_wmask", i), mem_wmask, 0);
            step();
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'hCAFE_F00D_0BAD_BEEF;
            @(negedge clk);
            chk($sformatf("tie%0d_ls_rv", i), ls_rvalid, exp_ls[i]);
            chk($sformatf("tie%0d_if_rv", i), if_rvalid, !exp_ls[i]);
        end
        step();
        idle_inputs();

        // Grant stall: five cycles without mem_gnt.
        if_req = 1; if_addr = 64'h8000_0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_req", i),  mem_req,  1);
            chk($sformatf("stall%0d_addr", i), mem_addr, 64'h8000_0010);
            chk($sformatf("stall%0d_gnt", i),  if_gnt,   0);
            step();
        end
        mem_gnt = 1;
        @(negedge clk);
        chk("stall_gnt6", if_gnt, 1);
        step();
        if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        chk("stall_rdata", if_rdata, 32'h9ABC_DEF0);
        step();
        idle_inputs();

        // Store acknowledge.
        ls_req = 1; ls_we = 1; ls_addr = 64'h8000_1000;
        ls_wdata = 64'h0000_0000_DEAD_BEEF; ls_wmask = 8'h0F; mem_gnt = 1;
        @(negedge clk);
        chk("st_gnt",   ls_gnt,    1);
        chk("st_we",    mem_we,    1);
        chk("st_addr",  mem_addr,  64'h8000_1000);
        chk("st_wdata", mem_wdata, 64'h0000_0000_DEAD_BEEF);
        chk("st_wmask", mem_wmask, 8'h0F);
        step();
        idle_inputs();
        @(negedge clk);
        chk("st_wait_rv", ls_rvalid, 0);
        step();
        mem_rvalid = 1;
        @(negedge clk);
        chk("st_ack", ls_rvalid, 1);
        step();
        mem_rvalid = 0;
        @(negedge clk);
        chk("st_ack_once", ls_rvalid, 0);

        // Load: write mask forced to zero, full 64-bit data returned.
        step();
        ls_req = 1; ls_we = 0; ls_addr = 64'h8000_1008; ls_wmask = 8'hFF; mem_gnt = 1;
        @(negedge clk);
        chk("ld_gnt",   ls_gnt,    1);
        chk("ld_wmask", mem_wmask, 0);
        chk("ld_we",    mem_we,    0);
        step();
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 64'hFEDC_BA98_7654_3210;
        @(negedge clk);
        chk("ld_rv",    ls_rvalid, 1);
        chk("ld_rdata", ls_rdata,  64'hFEDC_BA98_7654_3210);
        step();
        idle_inputs();

        // Reset in WAIT_LS abandons the transaction.
        ls_req = 1; ls_we = 0; ls_addr = 64'h8000_4000; mem_gnt = 1;
        @(negedge clk);
        chk("rmid_gnt", ls_gnt, 1);
        step();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("rmid_req", mem_req, 0);
        step();
        step();
        mem_rvalid = 1; mem_rdata = 64'h5555_6666_7777_8888;
        @(negedge clk);
        chk("rmid_ls_rv", ls_rvalid, 0);
        chk("rmid_if_rv", if_rvalid, 0);
        chk("rmid_rdata", ls_rdata,  0);
        step();
        idle_inputs();
        // Back in IDLE: a fresh fetch is granted immediately.
        if_req = 1; if_addr = 64'h8000_0008; mem_gnt = 1;
        @(negedge clk);
        chk("rmid_idle_gnt", if_gnt, 1);
        step();
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
